// File: rtl/kc_tap_loader.sv
// KC85/4 TAP loader: parses an hps_io TAP download and writes its payload through the memory arbiter port.
// Optional signature check is enabled by defining KC_TAP_SIG_CHECK_EN.
module kc_tap_loader #(
  parameter logic [7:0] TAP_INDEX = 8'd1,
  parameter int         BLK_SIZE  = 128
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_data,
  output logic        ioctl_wait,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        start_valid,
  output logic [15:0] start_addr
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SIG   = 3'd1;
  localparam logic [2:0] S_BNUM  = 3'd2;
  localparam logic [2:0] S_HDR   = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_WRITE = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;

  localparam logic [7:0] BLK_LAST = 8'(BLK_SIZE - 1);
  localparam logic [7:0] BLK_FULL = 8'(BLK_SIZE);

  logic [2:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        first_q, first_d;
  logic        dl_q, dl_d;
  logic        abort_q, abort_d;
  logic        viol_q, viol_d;
  logic [7:0]  argc_q, argc_d;
  logic [15:0] ptr_q, ptr_d;
  logic [15:0] end_q, end_d;
  logic [15:0] hdr_start_q, hdr_start_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        start_valid_q, start_valid_d;
  logic [15:0] start_addr_q, start_addr_d;
  logic [15:0] ptr_inc;
  logic        sig_ok;

`ifdef KC_TAP_SIG_CHECK_EN
  function automatic logic [7:0] sig_byte(input logic [3:0] idx);
    case (idx)
      4'd0:  sig_byte = 8'hC3;
      4'd1:  sig_byte = 8'h4B;
      4'd2:  sig_byte = 8'h43;
      4'd3:  sig_byte = 8'h2D;
      4'd4:  sig_byte = 8'h54;
      4'd5:  sig_byte = 8'h41;
      4'd6:  sig_byte = 8'h50;
      4'd7:  sig_byte = 8'h45;
      4'd8:  sig_byte = 8'h20;
      4'd9:  sig_byte = 8'h62;
      4'd10: sig_byte = 8'h79;
      4'd11: sig_byte = 8'h20;
      4'd12: sig_byte = 8'h41;
      4'd13: sig_byte = 8'h46;
      4'd14: sig_byte = 8'h2E;
      default: sig_byte = 8'h20;
    endcase
  endfunction

  assign sig_ok = (ioctl_data == sig_byte(cnt_q[3:0]));
`else
  assign sig_ok = 1'b1;
`endif

  assign ptr_inc = ptr_q + 16'd1;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    first_d       = first_q;
    dl_d          = ioctl_download;
    abort_d       = abort_q;
    viol_d        = viol_q;
    argc_d        = argc_q;
    ptr_d         = ptr_q;
    end_d         = end_q;
    hdr_start_d   = hdr_start_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    busy_d        = busy_q;
    done_d        = done_q;
    error_d       = error_q;
    start_valid_d = start_valid_q;
    start_addr_d  = start_addr_q;

    case (state_q)
      S_IDLE: begin
        if (ioctl_download && !dl_q && ioctl_index == TAP_INDEX) begin
          state_d       = S_SIG;
          cnt_d         = 8'd0;
          first_d       = 1'b1;
          abort_d       = 1'b0;
          viol_d        = 1'b0;
          argc_d        = 8'd0;
          busy_d        = 1'b1;
          done_d        = 1'b0;
          error_d       = 1'b0;
          start_valid_d = 1'b0;
          start_addr_d  = 16'd0;
        end
      end
      S_SIG: begin
        if (!ioctl_download) begin
          state_d = S_ERR;
        end else if (ioctl_wr) begin
          cnt_d = cnt_q + 8'd1;
          if (!sig_ok) begin
            state_d = S_ERR;
          end else if (cnt_q == 8'd15) begin
            state_d = S_BNUM;
            cnt_d   = 8'd0;
          end
        end
      end
      S_BNUM: begin
        if (!ioctl_download) begin
          state_d = S_ERR;
        end else if (ioctl_wr) begin
          cnt_d   = 8'd0;
          state_d = first_q ? S_HDR : S_DATA;
        end
      end
      S_HDR: begin
        if (!ioctl_download) begin
          state_d = S_ERR;
        end else if (ioctl_wr) begin
          cnt_d = cnt_q + 8'd1;
          case (cnt_q)
            8'd16: argc_d             = ioctl_data;
            8'd17: ptr_d[7:0]         = ioctl_data;
            8'd18: ptr_d[15:8]        = ioctl_data;
            8'd19: end_d[7:0]         = ioctl_data;
            8'd20: end_d[15:8]        = ioctl_data;
            8'd21: hdr_start_d[7:0]   = ioctl_data;
            8'd22: hdr_start_d[15:8]  = ioctl_data;
            default: ;
          endcase
          if (cnt_q == BLK_LAST) begin
            first_d = 1'b0;
            cnt_d   = 8'd0;
            if (end_q < ptr_q) begin
              state_d = S_ERR;
            end else begin
              state_d = (end_q == ptr_q) ? S_DONE : S_BNUM;
              if (argc_q >= 8'd3) begin
                start_valid_d = 1'b1;
                start_addr_d  = hdr_start_q;
              end
            end
          end
        end
      end
      S_DATA: begin
        if (!ioctl_download) begin
          state_d = S_ERR;
        end else if (ioctl_wr) begin
          cnt_d = cnt_q + 8'd1;
          if (ptr_q != end_q) begin
            mem_addr_d  = ptr_q;
            mem_wdata_d = ioctl_data;
            state_d     = S_WRITE;
          end else if (cnt_q == BLK_LAST) begin
            cnt_d   = 8'd0;
            state_d = S_BNUM;
          end
        end
      end
      S_WRITE: begin
        // Aborts seen while the write is pending are deferred until the grant.
        if (!ioctl_download) abort_d = 1'b1;
        if (ioctl_wr)        viol_d  = 1'b1;
        if (mem_gnt) begin
          ptr_d = ptr_inc;
          if (viol_q || ioctl_wr) begin
            state_d = S_ERR;
          end else if (ptr_inc == end_q) begin
            state_d = S_DONE;
          end else if (abort_q || !ioctl_download) begin
            state_d = S_ERR;
          end else if (cnt_q == BLK_FULL) begin
            cnt_d   = 8'd0;
            state_d = S_BNUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DONE, S_ERR: begin
        if (!ioctl_download) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_DONE) begin
      done_d = 1'b1;
      busy_d = 1'b0;
    end
    if (state_d == S_ERR) begin
      error_d = 1'b1;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= 8'd0;
      first_q       <= 1'b0;
      dl_q          <= 1'b0;
      abort_q       <= 1'b0;
      viol_q        <= 1'b0;
      argc_q        <= 8'd0;
      ptr_q         <= 16'd0;
      end_q         <= 16'd0;
      hdr_start_q   <= 16'd0;
      mem_addr_q    <= 16'd0;
      mem_wdata_q   <= 8'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      start_valid_q <= 1'b0;
      start_addr_q  <= 16'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      first_q       <= first_d;
      dl_q          <= dl_d;
      abort_q       <= abort_d;
      viol_q        <= viol_d;
      argc_q        <= argc_d;
      ptr_q         <= ptr_d;
      end_q         <= end_d;
      hdr_start_q   <= hdr_start_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
      start_valid_q <= start_valid_d;
      start_addr_q  <= start_addr_d;
    end
  end

  assign mem_req     = (state_q == S_WRITE);
  assign ioctl_wait  = (state_q == S_WRITE);
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign start_valid = start_valid_q;
  assign start_addr  = start_addr_q;

endmodule

// File: tb/tb_kc_tap_loader.sv
// Directed bench for kc_tap_loader: builds TAP images, plays them as hps_io downloads and grants writes.
// Expectations for the signature test follow KC_TAP_SIG_CHECK_EN.
module tb_kc_tap_loader;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wait;
  logic        mem_req;
  logic        mem_gnt;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic        start_valid;
  logic [15:0] start_addr;

  int checks = 0;
  int errors = 0;

  logic [7:0]  tap[$];
  int          gnt_delay;
  int          wr_cnt, wr_bad, stab_bad, hi_bad;
  logic [15:0] exp_base;
  int          req0, busy0;
  int          req_cycles = 0;
  int          busy_cycles = 0;

  always #5 clk_sys = ~clk_sys;

  kc_tap_loader dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_data     (ioctl_data),
    .ioctl_wait     (ioctl_wait),
    .mem_req        (mem_req),
    .mem_gnt        (mem_gnt),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .start_valid    (start_valid),
    .start_addr     (start_addr)
  );

  always @(negedge clk_sys) begin
    if (mem_req === 1'b1) req_cycles <= req_cycles + 1;
    if (busy === 1'b1)    busy_cycles <= busy_cycles + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [7:0] pay(input int i);
    return 8'((i * 7 + 17) & 255);
  endfunction

  function automatic logic [7:0] sig_byte(input int i);
    case (i)
      0: return 8'hC3;   1: return 8'h4B;   2: return 8'h43;   3: return 8'h2D;
      4: return 8'h54;   5: return 8'h41;   6: return 8'h50;   7: return 8'h45;
      8: return 8'h20;   9: return 8'h62;   10: return 8'h79;  11: return 8'h20;
      12: return 8'h41;  13: return 8'h46;  14: return 8'h2E;  default: return 8'h20;
    endcase
  endfunction

  task automatic build_tap(input logic [15:0] ld, input logic [15:0] en,
                           input logic [7:0] argc, input logic [15:0] st);
    int n, nblk;
    logic [7:0] b;
    tap.delete();
    for (int i = 0; i < 16; i++) tap.push_back(sig_byte(i));
    tap.push_back(8'h01);
    for (int i = 0; i < 128; i++) begin
      case (i)
        16: b = argc;
        17: b = ld[7:0];
        18: b = ld[15:8];
        19: b = en[7:0];
        20: b = en[15:8];
        21: b = st[7:0];
        22: b = st[15:8];
        default: b = (i < 16) ? 8'h41 : 8'h00;
      endcase
      tap.push_back(b);
    end
    n = (int'(en) > int'(ld)) ? int'(en) - int'(ld) : 0;
    nblk = (n + 127) / 128;
    if (nblk == 0) nblk = 1;
    for (int k = 0; k < nblk; k++) begin
      tap.push_back(8'(k + 2));
      for (int i = 0; i < 128; i++)
        tap.push_back((k * 128 + i < n) ? pay(k * 128 + i) : 8'hEE);
    end
  endtask

  task automatic begin_test(input logic [15:0] base, input int dly);
    exp_base  = base;
    gnt_delay = dly;
    wr_cnt    = 0;
    wr_bad    = 0;
    stab_bad  = 0;
    hi_bad    = 0;
    req0      = req_cycles;
    busy0     = busy_cycles;
  endtask

  // One strobe; if it opens a write, hold the grant back gnt_delay cycles and audit the handshake.
  task automatic send_byte(input logic [7:0] bval);
    logic [15:0] a;
    logic [7:0]  d;
    int          hi;
    ioctl_data = bval;
    ioctl_wr   = 1'b1;
    tick;
    ioctl_wr   = 1'b0;
    if (mem_req === 1'b1) begin
      a  = mem_addr;
      d  = mem_wdata;
      hi = 0;
      for (int k = 0; k <= gnt_delay; k++) begin
        if (mem_req === 1'b1 && ioctl_wait === 1'b1) hi++;
        if (mem_addr !== a || mem_wdata !== d) stab_bad++;
        if (k == gnt_delay) mem_gnt = 1'b1;
        tick;
      end
      mem_gnt = 1'b0;
      if (mem_req !== 1'b0 || ioctl_wait !== 1'b0) stab_bad++;
      if (hi != gnt_delay + 1) hi_bad++;
      if (a !== exp_base + 16'(wr_cnt) || d !== pay(wr_cnt)) wr_bad++;
      wr_cnt++;
    end
  endtask

  task automatic send_range(input int from, input int upto);
    for (int i = from; i < upto && i < tap.size(); i++) send_byte(tap[i]);
  endtask

  task automatic dl_start(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick;
    tick;
  endtask

  task automatic dl_stop;
    ioctl_download = 1'b0;
    tick;
    tick;
  endtask

  initial begin
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b0;
    ioctl_data     = 8'd0;
    mem_gnt        = 1'b0;
    tick;
    tick;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_ioctl_wait", ioctl_wait, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_start_valid", start_valid, 0);
    chk("rst_start_addr", start_addr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    reset_n = 1'b1;
    tick;

    // Basic load, immediate grant
    build_tap(16'h0300, 16'h0310, 8'd3, 16'h0305);
    begin_test(16'h0300, 0);
    dl_start(8'd1);
    send_range(0, 20);
    chk("t1_busy_mid", busy, 1);
    send_range(20, tap.size());
    chk("t1_busy_end", busy, 0);
    dl_stop;
    chk("t1_writes", wr_cnt, 16);
    chk("t1_image", wr_bad, 0);
    chk("t1_req_cycles", req_cycles - req0, 16);
    chk("t1_done", done, 1);
    chk("t1_error", error, 0);
    chk("t1_start_valid", start_valid, 1);
    chk("t1_start_addr", start_addr, 16'h0305);
    $display("t1 basic load: writes=%0d done=%0b start=%h", wr_cnt, done, start_addr);

    // Same file, grant delayed 5 cycles
    begin_test(16'h0300, 5);
    dl_start(8'd1);
    send_range(0, tap.size());
    dl_stop;
    chk("t2_writes", wr_cnt, 16);
    chk("t2_image", wr_bad, 0);
    chk("t2_hold_cycles", hi_bad, 0);
    chk("t2_stable", stab_bad, 0);
    chk("t2_req_cycles", req_cycles - req0, 96);
    chk("t2_done", done, 1);
    $display("t2 delayed grant: writes=%0d req_cycles=%0d", wr_cnt, req_cycles - req0);

    // Zero-length and inverted ranges
    build_tap(16'h0300, 16'h0300, 8'd3, 16'h0300);
    begin_test(16'h0300, 0);
    dl_start(8'd1);
    send_range(0, tap.size());
    dl_stop;
    chk("t3a_req", req_cycles - req0, 0);
    chk("t3a_done", done, 1);
    chk("t3a_error", error, 0);
    $display("t3a zero length: done=%0b error=%0b", done, error);
    build_tap(16'h0300, 16'h02FF, 8'd3, 16'h0300);
    begin_test(16'h0300, 0);
    dl_start(8'd1);
    send_range(0, tap.size());
    dl_stop;
    chk("t3b_req", req_cycles - req0, 0);
    chk("t3b_error", error, 1);
    chk("t3b_done", done, 0);
    $display("t3b end<load: done=%0b error=%0b", done, error);

    // Two payload blocks with trailing padding, two header args
    build_tap(16'h1000, 16'h10C8, 8'd2, 16'h1234);
    begin_test(16'h1000, 0);
    dl_start(8'd1);
    send_range(0, tap.size());
    dl_stop;
    chk("t4_writes", wr_cnt, 200);
    chk("t4_image", wr_bad, 0);
    chk("t4_done", done, 1);
    chk("t4_start_valid", start_valid, 0);
    $display("t4 two blocks: writes=%0d done=%0b", wr_cnt, done);

    // Truncated download after 50 payload bytes
    build_tap(16'h2000, 16'h2080, 8'd3, 16'h2000);
    begin_test(16'h2000, 0);
    dl_start(8'd1);
    send_range(0, 16 + 129 + 1 + 50);
    dl_stop;
    chk("t5_writes", wr_cnt, 50);
    chk("t5_image", wr_bad, 0);
    chk("t5_error", error, 1);
    chk("t5_done", done, 0);
    chk("t5_busy", busy, 0);
    $display("t5 truncated: writes=%0d error=%0b busy=%0b", wr_cnt, error, busy);

    // Asynchronous reset while a write is pending
    build_tap(16'h0300, 16'h0310, 8'd3, 16'h0305);
    begin_test(16'h0300, 0);
    dl_start(8'd1);
    send_range(0, 16 + 129 + 1);
    ioctl_data = 8'h55;
    ioctl_wr   = 1'b1;
    tick;
    ioctl_wr   = 1'b0;
    chk("t6_req_before", mem_req, 1);
    chk("t6_sv_before", start_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("t6_req", mem_req, 0);
    chk("t6_wait", ioctl_wait, 0);
    chk("t6_busy", busy, 0);
    chk("t6_start_valid", start_valid, 0);
    chk("t6_start_addr", start_addr, 0);
    chk("t6_mem_addr", mem_addr, 0);
    chk("t6_mem_wdata", mem_wdata, 0);
    ioctl_download = 1'b0;
    tick;
    reset_n = 1'b1;
    tick;
    $display("t6 reset in write: mem_req=%0b busy=%0b", mem_req, busy);

    // Foreign download index is ignored
    build_tap(16'h0300, 16'h0310, 8'd3, 16'h0305);
    begin_test(16'h0300, 0);
    dl_start(8'd2);
    send_range(0, tap.size());
    dl_stop;
    chk("t7_busy_cycles", busy_cycles - busy0, 0);
    chk("t7_req", req_cycles - req0, 0);
    chk("t7_done", done, 0);
    $display("t7 index 2: busy_cycles=%0d", busy_cycles - busy0);

    // Corrupted signature byte 1
    build_tap(16'h0300, 16'h0310, 8'd3, 16'h0305);
    tap[1] = 8'h4C;
    begin_test(16'h0300, 0);
    dl_start(8'd1);
    send_range(0, tap.size());
    dl_stop;
`ifdef KC_TAP_SIG_CHECK_EN
    chk("t8_error", error, 1);
    chk("t8_req", req_cycles - req0, 0);
    chk("t8_writes", wr_cnt, 0);
`else
    chk("t8_done", done, 1);
    chk("t8_writes", wr_cnt, 16);
    chk("t8_image", wr_bad, 0);
`endif
    $display("t8 bad signature: done=%0b error=%0b writes=%0d", done, error, wr_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
